// File: rtl/framebuffer_pkg.sv
// Shared frame buffer definitions used by both the capture and read sides.
//   IMAGE_WIDTH / IMAGE_HEIGHT / IMAGE_SIZE : frame geometry in pixels
//   rgb565_t                                : packed RGB565 pixel layout
//   readerState_t                           : read-side controller states
package framebuffer_pkg;

  localparam int IMAGE_WIDTH  = 80;
  localparam int IMAGE_HEIGHT = 48;
  localparam int IMAGE_SIZE   = IMAGE_WIDTH * IMAGE_HEIGHT;

  typedef struct packed {
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
  } rgb565_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } readerState_t;

endpackage

// File: rtl/framebuffer_reader_pixel_fifo.sv
// Show-ahead synchronous FIFO used to buffer pixels between the RAM read
// pipeline and the downstream valid/ready stream.
//   clk, rst   : clock, asynchronous active-high reset
//   push/pushData : write one entry (ignored when full unless popping too)
//   pop        : consume the head entry (ignored when empty)
//   headData   : current head entry, valid whenever empty is low
//   count      : number of stored entries
//   empty/full : occupancy flags
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             pushData,
  input  logic                         pop,
  output logic [WIDTH-1:0]             headData,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign doPop    = pop && !empty;
  assign doPush   = push && (!full || doPop);
  assign headData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= nextPtr(wrPtr);
      end
      if (doPop) begin
        rdPtr <= nextPtr(rdPtr);
      end
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/framebuffer_reader.sv
// Read side of the frame RAM. A frameStart pulse reads one full image from
// addresses 0..IMAGE_SIZE-1 and streams it out as a valid/ready pixel stream
// tagged with line-end and frame-end flags.
//   clk, rst        : clock, asynchronous active-high reset
//   frameStart      : one-cycle request to read a frame
//   busy            : frame read in progress
//   frameOverrun    : one-cycle pulse when frameStart arrives while busy
//   ramAddr/ramReadEnable/ramData : RAM read port, data one cycle after strobe
//   pixelData/pixelLineEnd/pixelFrameEnd/pixelValid/pixelReady : output stream
module framebuffer_reader #(
  parameter int RAM_ADDR_WIDTH = 32,
  parameter int RAM_DATA_WIDTH = 16,
  parameter int IMAGE_WIDTH    = framebuffer_pkg::IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT   = framebuffer_pkg::IMAGE_HEIGHT,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frameStart,
  output logic                      busy,
  output logic                      frameOverrun,
  output logic [RAM_ADDR_WIDTH-1:0] ramAddr,
  output logic                      ramReadEnable,
  input  logic [RAM_DATA_WIDTH-1:0] ramData,
  output logic [RAM_DATA_WIDTH-1:0] pixelData,
  output logic                      pixelLineEnd,
  output logic                      pixelFrameEnd,
  output logic                      pixelValid,
  input  logic                      pixelReady
);

  import framebuffer_pkg::*;

  localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int COL_W      = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int ENTRY_W    = RAM_DATA_WIDTH + 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  readerState_t              state;
  readerState_t              stateNext;
  logic [RAM_ADDR_WIDTH-1:0] addrCounter;
  logic [COL_W-1:0]          colCounter;
  logic                      issuedLineEnd;
  logic                      issuedFrameEnd;
  logic                      capValid;
  logic                      capLineEnd;
  logic                      capFrameEnd;
  logic                      issueOk;
  logic                      lastAddr;
  logic                      lastCol;

  logic [ENTRY_W-1:0]        fifoHead;
  logic [CNT_W-1:0]          fifoCount;
  logic                      fifoEmpty;
  logic                      fifoFull;

  assign lastAddr = (addrCounter == RAM_ADDR_WIDTH'(IMAGE_SIZE - 1));
  assign lastCol  = (colCounter == COL_W'(IMAGE_WIDTH - 1));

  // Credit check counts every read not yet visible in fifoCount: the strobe
  // on the RAM port and the word returning in the capture cycle.
  assign issueOk = (state == READ) && !fifoFull &&
                   ((32'(fifoCount) + 32'(ramReadEnable) + 32'(capValid))
                    < 32'(FIFO_DEPTH));

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (frameStart) stateNext = READ;
      READ:    if (issueOk && lastAddr) stateNext = DRAIN;
      DRAIN:   if (fifoEmpty && !ramReadEnable && !capValid) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      frameOverrun   <= 1'b0;
      addrCounter    <= '0;
      colCounter     <= '0;
      ramAddr        <= '0;
      ramReadEnable  <= 1'b0;
      issuedLineEnd  <= 1'b0;
      issuedFrameEnd <= 1'b0;
      capValid       <= 1'b0;
      capLineEnd     <= 1'b0;
      capFrameEnd    <= 1'b0;
    end else begin
      state        <= stateNext;
      frameOverrun <= frameStart && (state != IDLE);
      capValid     <= ramReadEnable;
      capLineEnd   <= issuedLineEnd;
      capFrameEnd  <= issuedFrameEnd;
      if ((state == IDLE) && frameStart) begin
        addrCounter <= '0;
        colCounter  <= '0;
      end
      if (issueOk) begin
        ramReadEnable  <= 1'b1;
        ramAddr        <= addrCounter;
        issuedLineEnd  <= lastCol;
        issuedFrameEnd <= lastAddr;
        addrCounter    <= addrCounter + 1'b1;
        colCounter     <= lastCol ? '0 : colCounter + 1'b1;
      end else begin
        ramReadEnable <= 1'b0;
      end
    end
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) uPixelFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (capValid),
    .pushData ({ramData, capLineEnd, capFrameEnd}),
    .pop      (pixelValid && pixelReady),
    .headData (fifoHead),
    .count    (fifoCount),
    .empty    (fifoEmpty),
    .full     (fifoFull)
  );

  assign busy       = (state != IDLE);
  assign pixelValid = !fifoEmpty;
  // Head is masked while empty so the stream outputs read 0 out of reset.
  assign {pixelData, pixelLineEnd, pixelFrameEnd} = pixelValid ? fifoHead : '0;

endmodule

// File: tb/tb_framebuffer_reader.sv
module tb_framebuffer_reader;

  localparam int W     = 80;
  localparam int H     = 48;
  localparam int N     = W * H;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        frameStart;
  logic        busy;
  logic        frameOverrun;
  logic [31:0] ramAddr;
  logic        ramReadEnable;
  logic [15:0] ramData = '0;
  logic [15:0] pixelData;
  logic        pixelLineEnd;
  logic        pixelFrameEnd;
  logic        pixelValid;
  logic        pixelReady;

  always #5 clk = ~clk;

  framebuffer_reader #(
    .RAM_ADDR_WIDTH (32),
    .RAM_DATA_WIDTH (16),
    .IMAGE_WIDTH    (W),
    .IMAGE_HEIGHT   (H),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frameStart    (frameStart),
    .busy          (busy),
    .frameOverrun  (frameOverrun),
    .ramAddr       (ramAddr),
    .ramReadEnable (ramReadEnable),
    .ramData       (ramData),
    .pixelData     (pixelData),
    .pixelLineEnd  (pixelLineEnd),
    .pixelFrameEnd (pixelFrameEnd),
    .pixelValid    (pixelValid),
    .pixelReady    (pixelReady)
  );

  function automatic logic [15:0] ramVal(input int unsigned a);
    return 16'(a * 7 + 32'h1234);
  endfunction

  // RAM model: registered read, data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (ramReadEnable) ramData <= ramVal(ramAddr);
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state, advanced once per cycle at the falling edge.
  bit mActive, mOvr, dropPending, lastSeen, wasActive;
  int mIssued, mDelivered, mLineEnds, mFrameEnds, mOvrCount;
  int readyMode = 0;
  int stallLeft = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mActive = 0; mOvr = 0; dropPending = 0;
        mIssued = 0; mDelivered = 0;
      end else begin
        check("busy", 32'(busy), 32'(mActive));
        check("frameOverrun", 32'(frameOverrun), 32'(mOvr));
        if (frameOverrun) mOvrCount++;
        if (ramReadEnable) begin
          check("ramAddr", ramAddr, 32'(mIssued));
          mIssued++;
          check("inFlightBound", 32'(mIssued - mDelivered <= DEPTH), 32'd1);
        end
        lastSeen = 0;
        if (pixelValid) begin
          check("beatInRange", 32'(mDelivered < N), 32'd1);
          check("pixelData", 32'(pixelData), 32'(ramVal(mDelivered)));
          check("pixelLineEnd", 32'(pixelLineEnd), 32'((mDelivered % W) == W - 1));
          check("pixelFrameEnd", 32'(pixelFrameEnd), 32'(mDelivered == N - 1));
          if (pixelReady) begin
            if (pixelLineEnd) mLineEnds++;
            if (pixelFrameEnd) mFrameEnds++;
            mDelivered++;
            if (mDelivered == N) lastSeen = 1;
          end
        end
        wasActive = mActive;
        mOvr = frameStart && wasActive;
        if (dropPending) begin
          mActive = 0;
          dropPending = 0;
        end
        if (lastSeen) dropPending = 1;
        if (frameStart && !wasActive) begin
          mActive = 1; mIssued = 0; mDelivered = 0;
          mLineEnds = 0; mFrameEnds = 0; mOvrCount = 0;
        end
      end
    end
  end

  // Downstream ready pattern: 0 = always ready, 1 = toggling, 2 = one stall.
  bit phase = 0;
  initial begin
    pixelReady = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      phase = ~phase;
      case (readyMode)
        1: pixelReady = phase;
        2: begin
          if (mDelivered >= 500 && stallLeft > 0) begin
            pixelReady = 1'b0;
            stallLeft--;
          end else begin
            pixelReady = 1'b1;
          end
        end
        default: pixelReady = 1'b1;
      endcase
    end
  end

  task automatic pulseStart();
    @(posedge clk); #1 frameStart = 1'b1;
    @(posedge clk); #1 frameStart = 1'b0;
  endtask

  task automatic waitFrame(input int expOvr);
    int n = 0;
    while ((mActive || busy || mDelivered < N) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check("frameTimeout", 32'(n < 30000), 32'd1);
    check("beatCount", 32'(mDelivered), 32'd3840);
    check("lineEndCount", 32'(mLineEnds), 32'd48);
    check("frameEndCount", 32'(mFrameEnds), 32'd1);
    check("overrunCount", 32'(mOvrCount), 32'(expOvr));
    repeat (3) @(posedge clk);
  endtask

  task automatic waitDelivered(input int target);
    int n = 0;
    while (mDelivered < target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("deliverTimeout", 32'(n < 20000), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    frameStart = 1'b0;
    #12;
    check("rstBusy", 32'(busy), 32'd0);
    check("rstValid", 32'(pixelValid), 32'd0);
    check("rstRen", 32'(ramReadEnable), 32'd0);
    check("rstAddr", ramAddr, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Frame 1: latency and full-rate streaming.
    readyMode = 0;
    @(posedge clk); #1 frameStart = 1'b1;
    @(posedge clk); #1 frameStart = 1'b0;          // after E0
    check("latBusyE0", 32'(busy), 32'd1);
    check("latRenE0", 32'(ramReadEnable), 32'd0);
    @(posedge clk); #1;                              // after E1
    check("latRenE1", 32'(ramReadEnable), 32'd1);
    check("latAddrE1", ramAddr, 32'd0);
    @(posedge clk); #1;                              // after E2
    check("latValidE2", 32'(pixelValid), 32'd0);
    @(posedge clk); #1;                              // after E3
    check("latValidE3", 32'(pixelValid), 32'd1);
    check("latData0", 32'(pixelData), 32'h1234);
    waitDelivered(79);
    @(posedge clk); #1;
    check("beat79Data", 32'(pixelData), 32'h145D);
    check("beat79LineEnd", 32'(pixelLineEnd), 32'd1);
    waitFrame(0);

    // Frame 2: 20-cycle stall at beat 500.
    readyMode = 2;
    stallLeft = 20;
    pulseStart();
    waitDelivered(500);
    repeat (10) @(posedge clk);
    #1;
    check("stallReady", 32'(pixelReady), 32'd0);
    check("stallRen", 32'(ramReadEnable), 32'd0);
    check("stallData", 32'(pixelData), 32'h1FE0);
    waitFrame(0);

    // Frame 3: ready toggling every cycle.
    readyMode = 1;
    pulseStart();
    waitFrame(0);

    // Frame 4: overrun at beat 100 and again while draining.
    readyMode = 0;
    pulseStart();
    waitDelivered(100);
    pulseStart();
    begin
      int n = 0;
      while (mIssued < N && n < 20000) begin
        @(negedge clk);
        n++;
      end
      check("issueTimeout", 32'(n < 20000), 32'd1);
    end
    pulseStart();
    waitFrame(2);

    // Frame 5: reset mid-frame, then a clean frame from address 0.
    pulseStart();
    waitDelivered(1000);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("abortBusy", 32'(busy), 32'd0);
    check("abortOvr", 32'(frameOverrun), 32'd0);
    check("abortAddr", ramAddr, 32'd0);
    check("abortRen", 32'(ramReadEnable), 32'd0);
    check("abortData", 32'(pixelData), 32'd0);
    check("abortLineEnd", 32'(pixelLineEnd), 32'd0);
    check("abortFrameEnd", 32'(pixelFrameEnd), 32'd0);
    check("abortValid", 32'(pixelValid), 32'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    pulseStart();
    waitFrame(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
